// File: rtl/conv_pkg.sv
// Shared pixel/window types and sizing helper for the conv_3x3 window generator.
package conv_pkg;
  localparam int PIX_W = 64;
  localparam int LANES = 8;

  typedef logic [PIX_W-1:0]   pixel_t;
  typedef pixel_t [0:2][0:2]  window_t;

  // Counter/address width for a 0..n-1 range, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/conv_line_buffer.sv
// One line-buffer bank: combinational read, write on the clock, so a read and
// write to the same address in one cycle returns the old word.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                    clk,
  input  logic                    we_i,
  input  logic [cnt_w(DEPTH)-1:0] addr_i,
  input  pixel_t                  wdata_i,
  output pixel_t                  rdata_o
);
  pixel_t mem [DEPTH];

  assign rdata_o = mem[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= wdata_i;
  end
endmodule

// File: rtl/conv_window_gen.sv
// Turns a raster NHWC beat stream into 3x3 windows for conv_3x3 using a
// two-row line buffer and one column shift register per window row.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int IMG_W     = 16,
  parameter int IMG_H     = 16,
  parameter int CH_GROUPS = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    clr_i,
  input  logic    s_valid_i,
  output logic    s_ready_o,
  input  pixel_t  s_data_i,
  output logic    win_valid_o,
  output logic    win_last_ch_o,
  output window_t win_pixels_o,
  output logic    frame_done_o
);
  localparam int CGW   = cnt_w(CH_GROUPS);
  localparam int CW    = cnt_w(IMG_W);
  localparam int RW    = cnt_w(IMG_H);
  localparam int DEPTH = IMG_W * CH_GROUPS;
  localparam int AW    = cnt_w(DEPTH);
  localparam int SR_D  = 3 * CH_GROUPS;

  logic [CGW-1:0] cg_q, cg_d, cg_p;
  logic [CW-1:0]  col_q, col_d, col_p;
  logic [RW-1:0]  row_q, row_d, row_p;
  logic           rdy_q;
  logic           win_q, last_q, done_q;
  logic           acc, win, last_cg, last_col, last_row;
  logic [AW-1:0]  addr;
  pixel_t         lb0_rd, lb1_rd;
  pixel_t [2:0]   row_in;
  pixel_t [2:0][SR_D-1:0] sr_q;

  assign s_ready_o = rdy_q;
  assign acc       = s_valid_i && rdy_q;

  // A clr beat is taken as the first beat of a new frame.
  always_comb begin
    cg_p     = clr_i ? '0 : cg_q;
    col_p    = clr_i ? '0 : col_q;
    row_p    = clr_i ? '0 : row_q;
    last_cg  = (cg_p  == CGW'(CH_GROUPS - 1));
    last_col = (col_p == CW'(IMG_W - 1));
    last_row = (row_p == RW'(IMG_H - 1));
    addr     = AW'(int'(col_p) * CH_GROUPS + int'(cg_p));
    win      = acc && (int'(row_p) >= 2) && (int'(col_p) >= 2);
    cg_d     = cg_p;
    col_d    = col_p;
    row_d    = row_p;
    if (acc) begin
      if (last_cg) begin
        cg_d = '0;
        if (last_col) begin
          col_d = '0;
          row_d = last_row ? '0 : row_p + 1'b1;
        end else begin
          col_d = col_p + 1'b1;
        end
      end else begin
        cg_d = cg_p + 1'b1;
      end
    end
  end

  conv_line_buffer #(.DEPTH(DEPTH)) u_lb0 (
    .clk(clk), .we_i(acc), .addr_i(addr), .wdata_i(s_data_i), .rdata_o(lb0_rd)
  );
  conv_line_buffer #(.DEPTH(DEPTH)) u_lb1 (
    .clk(clk), .we_i(acc), .addr_i(addr), .wdata_i(lb0_rd), .rdata_o(lb1_rd)
  );

  assign row_in = {s_data_i, lb0_rd, lb1_rd};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cg_q   <= '0;
      col_q  <= '0;
      row_q  <= '0;
      rdy_q  <= 1'b0;
      win_q  <= 1'b0;
      last_q <= 1'b0;
      done_q <= 1'b0;
      sr_q   <= '0;
    end else begin
      cg_q   <= cg_d;
      col_q  <= col_d;
      row_q  <= row_d;
      rdy_q  <= 1'b1;
      win_q  <= win;
      last_q <= win && last_cg;
      done_q <= win && last_cg && last_col && last_row;
      if (acc) begin
        for (int r = 0; r < 3; r++) sr_q[r] <= {sr_q[r][SR_D-2:0], row_in[r]};
      end
    end
  end

  // Tap k*CH_GROUPS holds the same channel group k columns back.
  always_comb begin
    win_pixels_o = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        win_pixels_o[i][j] = sr_q[i][(2 - j) * CH_GROUPS];
  end

  assign win_valid_o   = win_q;
  assign win_last_ch_o = last_q;
  assign frame_done_o  = done_q;
endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: three geometries, scoreboard of expected windows.
module tb_conv_window_gen;
  import conv_pkg::*;

  typedef struct {window_t pix; logic last; logic done;} exp_t;
  typedef struct {int dut; int frames; bit gaps; int clr_at; int rst_at; int exp_str; int exp_done;} tcase_t;

  localparam int GW[3] = '{4, 4, 5};
  localparam int GH[3] = '{4, 4, 3};
  localparam int GC[3] = '{1, 2, 1};

  logic    clk = 1'b0, rst_n = 1'b0, clr = 1'b0, s_valid = 1'b0;
  pixel_t  s_data = '0;
  int      act = 0;
  logic    sv [3], cl [3], rdy [3], wv [3], wl [3], fd [3];
  window_t wp [3];

  int checks = 0, failures = 0, strobes = 0, dones = 0;
  exp_t    q[$];
  window_t got_log[$];
  logic    acc_q = 1'b0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_drv
    assign sv[k] = s_valid && (act == k);
    assign cl[k] = clr && (act == k);
  end

  conv_window_gen #(.IMG_W(4), .IMG_H(4), .CH_GROUPS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr_i(cl[0]), .s_valid_i(sv[0]), .s_ready_o(rdy[0]),
    .s_data_i(s_data), .win_valid_o(wv[0]), .win_last_ch_o(wl[0]),
    .win_pixels_o(wp[0]), .frame_done_o(fd[0]));
  conv_window_gen #(.IMG_W(4), .IMG_H(4), .CH_GROUPS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr_i(cl[1]), .s_valid_i(sv[1]), .s_ready_o(rdy[1]),
    .s_data_i(s_data), .win_valid_o(wv[1]), .win_last_ch_o(wl[1]),
    .win_pixels_o(wp[1]), .frame_done_o(fd[1]));
  conv_window_gen #(.IMG_W(5), .IMG_H(3), .CH_GROUPS(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .clr_i(cl[2]), .s_valid_i(sv[2]), .s_ready_o(rdy[2]),
    .s_data_i(s_data), .win_valid_o(wv[2]), .win_last_ch_o(wl[2]),
    .win_pixels_o(wp[2]), .frame_done_o(fd[2]));

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic pixel_t pix(input int off, input int r, input int c, input int g);
    logic [7:0] b;
    b = 8'(off + r * 16 + c + g * 128);
    return {8{b}};
  endfunction

  always @(posedge clk) acc_q <= s_valid && rdy[act];

  // Scoreboard: every strobe must follow an accept and match the queued window.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wv[act]) begin
        exp_t e;
        strobes++;
        got_log.push_back(wp[act]);
        if (fd[act]) dones++;
        chk("strobe_after_accept", 64'(acc_q), 64'd1);
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_strobe: got strobe expected none");
        end else begin
          e = q.pop_front();
          if (wp[act] !== e.pix) begin
            failures++;
            $display("FAIL window: got %h expected %h", wp[act], e.pix);
          end
          chk("win_last_ch", 64'(wl[act]), 64'(e.last));
          chk("frame_done", 64'(fd[act]), 64'(e.done));
        end
      end else if (fd[act]) begin
        chk("frame_done_without_strobe", 64'(fd[act]), 64'd0);
      end
    end
  end

  task automatic send(input pixel_t d, input logic c, input bit push, input exp_t e);
    s_valid = 1'b1;
    s_data  = d;
    clr     = c;
    if (push) q.push_back(e);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    clr     = 1'b0;
  endtask

  // Streams up to nb beats (nb<0: whole frame) of a frame in raster order.
  task automatic stream(input int off, input int nb, input bit clr_first, input bit gaps);
    int n = 0;
    for (int r = 0; r < GH[act]; r++)
      for (int c = 0; c < GW[act]; c++)
        for (int g = 0; g < GC[act]; g++) begin
          exp_t e;
          bit   push;
          if (n == nb) return;
          if (gaps) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
          push = (r >= 2) && (c >= 2);
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              e.pix[i][j] = push ? pix(off, r - 2 + i, c - 2 + j, g) : '0;
          e.last = (g == GC[act] - 1);
          e.done = e.last && (r == GH[act] - 1) && (c == GW[act] - 1);
          send(pix(off, r, c, g), clr_first && (n == 0), push, e);
          n++;
        end
  endtask

  tcase_t tc[7];

  initial begin
    tc[0] = '{0, 1, 1'b0, -1, -1, 4, 1};
    tc[1] = '{1, 1, 1'b0, -1, -1, 8, 1};
    tc[2] = '{2, 1, 1'b0, -1, -1, 3, 1};
    tc[3] = '{2, 1, 1'b1, -1, -1, 3, 1};
    tc[4] = '{0, 2, 1'b0, -1, -1, 8, 2};
    tc[5] = '{0, 1, 1'b0,  6, -1, 4, 1};
    tc[6] = '{0, 1, 1'b0, -1,  9, 4, 1};

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset_ready", 64'(rdy[k]), 64'd0);
      chk("reset_win_valid", 64'(wv[k]), 64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk("ready_after_reset", 64'(rdy[k]), 64'd1);

    for (int t = 0; t < 7; t++) begin
      act = tc[t].dut;
      strobes = 0;
      dones = 0;
      got_log.delete();
      if (tc[t].clr_at >= 0) stream(0, tc[t].clr_at, 1'b0, tc[t].gaps);
      if (tc[t].rst_at >= 0) begin
        stream(0, tc[t].rst_at + 1, 1'b0, tc[t].gaps);
        rst_n = 1'b0;
        #1;
        chk("rst_win_valid", 64'(wv[act]), 64'd0);
        chk("rst_frame_done", 64'(fd[act]), 64'd0);
        chk("rst_last_ch", 64'(wl[act]), 64'd0);
        chk("rst_ready", 64'(rdy[act]), 64'd0);
        chk("rst_pixels_nonzero", 64'(wp[act] != '0), 64'd0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_midreset", 64'(rdy[act]), 64'd1);
      end
      for (int f = 0; f < tc[t].frames; f++)
        stream((tc[t].clr_at >= 0) ? 'h40 : f * 'h40, -1, (f == 0) && (tc[t].clr_at >= 0), tc[t].gaps);
      repeat (3) begin @(posedge clk); #1; end
      chk("queue_drained", 64'(q.size()), 64'd0);
      chk("strobe_count", 64'(strobes), 64'(tc[t].exp_str));
      chk("frame_done_count", 64'(dones), 64'(tc[t].exp_done));

      if (got_log.size() >= tc[t].exp_str) begin
        case (t)
          0: begin
            chk("t0_first_centre", 64'(got_log[0][1][1][7:0]), 64'h11);
            chk("t0_first_00", 64'(got_log[0][0][0][7:0]), 64'h00);
            chk("t0_first_22", 64'(got_log[0][2][2][7:0]), 64'h22);
            chk("t0_last_22", 64'(got_log[3][2][2][7:0]), 64'h33);
          end
          1: begin
            chk("t1_centre_cg0", 64'(got_log[0][1][1][7:0]), 64'h11);
            chk("t1_centre_cg1", 64'(got_log[1][1][1][7:0]), 64'h91);
          end
          4: chk("t4_second_frame_centre", 64'(got_log[4][1][1][7:0]), 64'h51);
          5: chk("t5_clr_beat_at_00", 64'(got_log[0][0][0][7:0]), 64'h40);
          default: ;
        endcase
      end else begin
        chk("strobe_log_size", 64'(got_log.size()), 64'(tc[t].exp_str));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Producer side of the conv_3x3 input interface.
- Consumes a raster NHWC pixel stream of 64-bit beats: 8 int8 channels per beat, channel-group fastest, then column, then row.
- Emits 3x3 pixel windows with a one-cycle valid strobe and a last-channel flag, wired directly to conv_3x3 pixels/valid_in/last_channel.
- Valid convolution, no padding. Two-row line buffer plus a per-row column shift register.

Parameters:
- IMG_W, 16, frame width in pixels (>=3)
- IMG_H, 16, frame height in pixels (>=3)
- CH_GROUPS, 4, input channels / 8 (beats per pixel, >=1)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous frame restart; clears counters
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accept
- s_data  in  64  one channel group, byte k = channel 8*cg+k
- win_valid  out  1  window strobe, maps to conv_3x3 valid_in
- win_last_ch  out  1  final channel group of this output pixel, maps to last_channel
- win_pixels  out  3x3x64  [row][col], row 0 = oldest row, col 0 = leftmost
- frame_done  out  1  one-cycle pulse alongside the final window of a frame

Behaviour:
- Reset: all outputs 0, counters 0. s_ready is 0 while rst_n is low and 1 from the first clk edge after release. Line-buffer RAM is not cleared; the first two rows of a frame always overwrite it before it is read.
- Accept occurs on s_valid && s_ready. No output backpressure, because conv_3x3 is fully pipelined, so s_ready stays 1.
- Counters cg (0..CH_GROUPS-1), col (0..IMG_W-1), row (0..IMG_H-1) advance per accept:
  - cg wraps and increments col.
  - col wraps and increments row.
  - row wraps to 0 at frame end.
- Line buffer addr = col*CH_GROUPS+cg, depth IMG_W*CH_GROUPS. Two banks: lb0 holds row-1, lb1 holds row-2.
  - On accept, read lb0[addr] and lb1[addr].
  - Write lb1[addr] <= lb0 read value.
  - Write lb0[addr] <= s_data.
  - Read-before-write per address.
- Column shift registers, one per window row, depth 3*CH_GROUPS. Each shifts in its row word on accept: row 2 takes s_data, row 1 takes lb0 out, row 0 takes lb1 out. Taps at offsets 0, CH_GROUPS and 2*CH_GROUPS give cols 2, 1, 0.
- Latency: win_valid is asserted the cycle after an accept whose pre-increment row>=2 and col>=2. win_pixels holds that window until the next accept. win_last_ch = (cg==CH_GROUPS-1) for that beat.
- Window count per frame: (IMG_H-2)*(IMG_W-2)*CH_GROUPS strobes.
- frame_done: asserted with the strobe for row=IMG_H-1, col=IMG_W-1, cg=CH_GROUPS-1. Counters then wrap, so back-to-back frames need no gap.
- clr and accept in the same cycle: clr wins the counter update, and the beat is taken as row0/col0/cg0 of the new frame. No window is emitted for that beat. Any registered win_valid/frame_done from the previous cycle still completes.
- clr with no accept: counters go to 0 and outputs are unaffected beyond their one-cycle strobes.
- Reset mid-frame: everything restarts. The next accepted beat is row0/col0/cg0.
- Idle cycles (s_valid=0) between beats: no state change, and win_valid=0.
- Arithmetic: the datapath is move-only, with no width changes. Counter widths are $clog2 of each bound, minimum 1.

Decomposition:
- conv_pkg holds the shared types and constants: PIX_W=64, LANES=8, typedef pixel_t (logic [63:0]), typedef window_t (pixel_t [0:2][0:2]).
- Sub-module conv_line_buffer: a parameterized DEPTH, one-port read-then-write RAM with one bank per instance. It is instantiated twice or carries a 2-wide word.
- Shift registers and counters live in the top.

Test Plan:
- IMG_W=4, IMG_H=4, CH_GROUPS=1; every byte of the beat at (r,c) = r*16+c; 16 beats back-to-back.
  - Exactly 4 strobes, each with win_last_ch=1.
  - First strobe in the cycle after beat 10 has win_pixels[1][1] bytes = 0x11 and [0][0]=0x00, [2][2]=0x22.
  - frame_done coincides with the 4th strobe, which has [2][2]=0x33.
- Same geometry with CH_GROUPS=2; byte = r*16+c+cg*0x80.
  - 8 strobes, with win_last_ch alternating 0,1.
  - First pair has centre bytes 0x11 then 0x91.
- Input with random s_valid gaps (50% duty), IMG_W=5, IMG_H=3, CH_GROUPS=1.
  - 3 strobes, with identical window contents to the gapless run.
  - No strobe during idle cycles.
- Two frames back-to-back (4x4, CG=1); second frame bytes offset by 0x40.
  - 8 strobes total, frame_done twice.
  - Second-frame first window centre = 0x51, with no first-frame data leaking into it.
- Assert clr together with beat 6 of a frame, then stream a full 4x4 frame from that beat.
  - No strobe for the aborted partial frame.
  - Then 4 correct strobes with the beat-6 data at position (0,0).
- Drop rst_n mid-frame after beat 9.
  - Outputs go to 0 immediately.
  - After release, a fresh 4x4 frame gives 4 correct windows and one frame_done.
